uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver. It is the successor to the fixed 8N1 receiver and adds:
- configurable data width, parity and stop-bit count;
- an input synchroniser and start-bit glitch rejection;
- parity, framing and break detection;
- an asynchronous active-low reset.

It sits between the board RX pin and the byte-consumer logic (command parser / RX FIFO) in the same clock domain.

Parameters:
CLOCKS_PER_BIT, 217, i_Clk cycles per bit (25 MHz / 115200); legal values ≥ 4.
DATA_BITS, 8, data bits per frame; legal values 5..9.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_Clk  in  1  system clock; all logic on the rising edge.
i_Rst_n  in  1  asynchronous active-low reset.
i_RX_Serial  in  1  asynchronous serial line; idles high.
o_RX_DV  out  1  one-cycle pulse: frame complete, byte and status valid.
o_RX_Byte  out  DATA_BITS  received data, LSB = first bit on the wire.
o_Parity_Err  out  1  parity mismatch on the last frame.
o_Frame_Err  out  1  a stop bit was sampled low on the last frame.
o_Break  out  1  last frame was a break (all sampled bits 0).
o_Busy  out  1  high from start-bit detect until the FSM is back in IDLE.

Behaviour:
- Reset (async assert, sync release via clock): all outputs 0; synchroniser flops = 1; FSM = IDLE; counters = 0.
- Input: i_RX_Serial passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Bit counter: clk_cnt counts 0..CLOCKS_PER_BIT-1. HALF = (CLOCKS_PER_BIT-1)/2, integer division.
- IDLE:
  - rx_s == 0 → START, clk_cnt = 0, o_Busy = 1 on the next cycle.
- START:
  - When clk_cnt == HALF, sample rx_s.
  - 0 → DATA, clk_cnt = 0, bit_idx = 0.
  - 1 → glitch: back to IDLE, no DV, no flags changed.
- DATA:
  - When clk_cnt == CLOCKS_PER_BIT-1, shift rx_s into bit position bit_idx. This is the bit centre.
  - After bit DATA_BITS-1: go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY:
  - Sample at the bit centre.
  - Error when (XOR of data bits ^ sampled bit) != (PARITY_MODE == 1).
  - So the odd-parity total over data + parity must be 1; for even it must be 0.
- STOP:
  - Sample each of the STOP_BITS stop bits at its centre.
  - Any stop sample of 0 sets a pending frame error.
  - After the last stop sample → DONE.
- DONE (exactly one cycle):
  - o_RX_DV = 1.
  - o_RX_Byte, o_Parity_Err, o_Frame_Err and o_Break all update in this same cycle.
  - They hold until the next DV; they are never cleared by an aborted (glitch) start.
  - Break = frame error AND all data bits 0 AND (parity bit 0, or no parity).
  - Next state: frame error → WAIT_IDLE; otherwise IDLE (o_Busy = 0 next cycle).
- WAIT_IDLE:
  - Stay until rx_s == 1, then → IDLE. This prevents re-triggering inside a held break.
  - o_Busy stays 1 throughout.
- Frame completion timing:
  - The DONE cycle is the clock after the last stop-bit centre sample.
  - Nominal latency from the i_RX_Serial falling edge to o_RX_DV:
    2 + HALF + CLOCKS_PER_BIT·(DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) + 2 cycles (±1).
- Back-to-back frames: a start bit immediately after the stop bit is accepted. DONE lasts one cycle and IDLE detects the start on the next cycle. No frame is lost.
- Reset mid-frame: the frame is discarded, no DV, all outputs 0 immediately (asynchronous).
- DATA_BITS = 9: o_RX_Byte is 9 bits wide; parity covers all 9 bits.

Test Plan:
- Defaults (8N1, CLOCKS_PER_BIT = 217, 40 ns clock, bit period 8680 ns): send 0x3A → one DV pulse, o_RX_Byte = 0x3A, all error flags 0, o_Busy low afterwards.
- PARITY_MODE = 2, STOP_BITS = 2:
  - send 0x3A with parity bit 0 → DV, byte 0x3A, Parity_Err = 0;
  - resend with parity bit 1 → DV, byte 0x3A, Parity_Err = 1.
- Glitch: drive the line low for 3000 ns (less than half a bit) and then high → no DV, o_Busy returns to 0, previous byte and flags unchanged.
- Framing error and break:
  - send 0x55 with stop bit 0 → DV, Frame_Err = 1, Break = 0;
  - hold the line low for 12 bit periods → DV, byte 0x00, Frame_Err = 1, Break = 1, no further DV until the line goes high;
  - then a 0xA5 frame → byte 0xA5, all flags 0.
- Back-to-back: send 0x01, 0xFF, 0x80 with no idle gap between frames → three DV pulses in order, correct bytes.
- Assert i_Rst_n low mid-way through the data bits of 0xC3, release, then send 0x7E → no DV for 0xC3, outputs 0 during reset, next DV byte = 0x7E.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop input synchroniser, start-glitch rejection,
// configurable data width / parity / stop bits, parity, framing and break status.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int CLOCKS_PER_BIT = 217,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STP = 1'(STOP_BITS - 1);
    localparam bit               HAS_PAR  = (PARITY_MODE != 0);
    localparam bit               ODD      = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 sidx_q, sidx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 fpend_q, fpend_d;
    logic                 dv_q, dv_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 busy_q, busy_d;
    logic                 stop_err;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sidx_q    <= 1'b0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            fpend_q   <= 1'b0;
            dv_q      <= 1'b0;
            byte_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= i_RX_Serial;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sidx_q    <= sidx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            fpend_q   <= fpend_d;
            dv_q      <= dv_d;
            byte_q    <= byte_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sidx_d   = sidx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fpend_d  = fpend_q;
        dv_d     = 1'b0;
        byte_d   = byte_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        brk_d    = brk_q;
        stop_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = HAS_PAR ? S_PARITY : S_STOP;
                        sidx_d  = 1'b0;
                        fpend_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d    = '0;
                    stop_err = fpend_q | ~rx_s_q;
                    fpend_d  = stop_err;
                    if (sidx_q == LAST_STP) begin
                        // Status is latched on entry to DONE so it is valid alongside the DV pulse.
                        state_d = S_DONE;
                        dv_d    = 1'b1;
                        byte_d  = shift_q;
                        perr_d  = HAS_PAR && ((^shift_q ^ par_q) != ODD);
                        ferr_d  = stop_err;
                        brk_d   = stop_err && (shift_q == '0) && (!HAS_PAR || !par_q);
                    end else begin
                        sidx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = ferr_q ? S_WAIT_IDLE : S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign o_RX_DV      = dv_q;
    assign o_RX_Byte    = byte_q;
    assign o_Parity_Err = perr_q;
    assign o_Frame_Err  = ferr_q;
    assign o_Break      = brk_q;
    assign o_Busy       = busy_q;

endmodule
